logic_op_issue: RTL and testbench
=================================

// Module: logic_op_issue
// PURPOSE
//  Issue stage feeding the logic unit: accepts a MIPS logic instruction with its register operands,
//  decodes opcode/funct into the unit's 4-bit ctrl code, and selects operands A/B and destination.
//  Presents one registered issue slot downstream via a valid/ready handshake (full throughput).
//  Illegal or non-logic encodings are consumed, flagged and counted; they are never issued.
// PARAMETERS
//  CNT_W        8    width of the saturating illegal-instruction counter
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  flush        in   1   synchronous: drop the held issue slot, block input this cycle
//  in_valid     in   1   instruction/operands valid
//  in_ready     out  1   stage can accept this cycle
//  in_instr     in   32  MIPS instruction word
//  in_rs_val    in   32  value of register rs
//  in_rt_val    in   32  value of register rt
//  out_valid    out  1   issue slot holds a decoded op
//  out_ready    in   1   logic unit/writeback accepts the slot
//  out_ctrl     out  4   logic ctrl: AND 1000, OR 1110, XOR 0110, NOR 0001, PASS-A 1010
//  out_a        out  32  operand A
//  out_b        out  32  operand B
//  out_dest     out  5   destination register number
//  illegal      out  1   one-cycle pulse: an illegal instruction was consumed
//  illegal_cnt  out  CNT_W  saturating count of consumed illegal instructions
// BEHAVIOUR
//  - Reset: out_valid=0, out_ctrl=4'b0000, out_a=out_b=0, out_dest=0, illegal=0, illegal_cnt=0.
//  - in_ready = !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
//  - Latency 1 cycle: op accepted at edge N is visible with out_valid=1 after edge N.
//  - Slot update on accept of a legal op: load ctrl/a/b/dest, out_valid=1.
//  - Slot retire: out_valid && out_ready && no accept -> out_valid=0; fields hold last value.
//  - Simultaneous retire + accept: slot reloaded, out_valid stays 1 (back-to-back, no bubble).
//  - Held slot (out_valid && !out_ready): all out_* stable until retired or flushed.
//  - Decode, op=instr[31:26], funct=instr[5:0], imm=instr[15:0]:
//      op 000000 funct 100100/100101/100110/100111 -> AND/OR/XOR/NOR; A=rs_val, B=rt_val, dest=rd[15:11]
//      op 001100/001101/001110 -> AND/OR/XOR; A=rs_val, B={16'b0,imm}, dest=rt[20:16]
//      op 001111 (LUI) -> PASS-A; A={imm,16'b0}, B=0, dest=rt
//      anything else -> illegal.
//  - Illegal accept: slot not loaded (if slot retired same cycle, out_valid=0), illegal=1 next cycle,
//    illegal_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
//  - dest==0 is legal and issued unchanged; writeback discards $zero writes.
//  - flush: out_valid=0 next cycle, in_ready=0 this cycle; does not touch illegal_cnt. rst beats flush.
//  - rst mid-operation: slot discarded, counter cleared, no pulse emitted.
// STRUCTURE
//  - logic_pkg: ctrl code constants (CTRL_AND/OR/XOR/NOR/PASS_A), opcode and funct constants,
//    typedef issue_slot_t {ctrl, a, b, dest}.
//  - Sub-module logic_op_decode (combinational): instr,rs_val,rt_val -> issue_slot_t + legal bit.
//  - Top: handshake logic, slot register, illegal pulse/counter.
// TESTING
//  1. AND $3,$1,$2 (0x00221824), rs=0xF0F0_F0F0, rt=0xFF00_FF00, out_ready=1
//     -> next cycle ctrl=1000, a=0xF0F0F0F0, b=0xFF00FF00, dest=3, out_valid=1.
//  2. ORI $5,$4,0xBEEF then LUI $6,0x1234 back-to-back, out_ready=1 -> ctrl=1110 b=0x0000BEEF dest=5,
//     then ctrl=1010 a=0x12340000 b=0 dest=6, out_valid high both cycles, in_ready never drops.
//  3. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> drains in order.
//  4. Illegal 0x8C000000 (LW) -> no issue, illegal pulse 1 cycle, illegal_cnt 0->1; 300 illegals -> cnt=255.
//  5. flush with slot held and in_valid=1 -> in_ready=0, out_valid=0 next cycle, input not consumed.
//  6. rst asserted while slot held and cnt=7 -> next cycle out_valid=0, illegal_cnt=0, all out_*=0.

Source files
------------

// File: rtl/logic_pkg.sv
// Package shared by the logic-unit issue stage.
// Holds the logic unit ctrl codes, MIPS opcode/funct encodings of the
// logic instructions, and the issue slot record passed to the logic unit.
package logic_pkg;

  // Ctrl codes understood by the logic unit.
  localparam logic [3:0] CTRL_AND    = 4'b1000;
  localparam logic [3:0] CTRL_OR     = 4'b1110;
  localparam logic [3:0] CTRL_XOR    = 4'b0110;
  localparam logic [3:0] CTRL_NOR    = 4'b0001;
  localparam logic [3:0] CTRL_PASS_A = 4'b1010;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes (instr[5:0]).
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // One decoded operation as presented to the logic unit.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
  } issue_slot_t;

endpackage

// File: rtl/logic_op_decode.sv
// Combinational decoder for the MIPS logic instructions.
// Ports:
//   instr   in  32  instruction word
//   rs_val  in  32  value of register rs
//   rt_val  in  32  value of register rt
//   slot    out     decoded ctrl / operand A / operand B / destination
//   legal   out 1   instruction is one of the supported logic ops
module logic_op_decode
  import logic_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output issue_slot_t slot,
  output logic        legal
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // rs/shamt field bits are never needed: register values arrive already read.
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    slot  = '0;
    legal = 1'b0;
    case (op)
      OP_SPECIAL: begin
        slot.a    = rs_val;
        slot.b    = rt_val;
        slot.dest = instr[15:11];
        legal     = 1'b1;
        case (funct)
          FN_AND:  slot.ctrl = CTRL_AND;
          FN_OR:   slot.ctrl = CTRL_OR;
          FN_XOR:  slot.ctrl = CTRL_XOR;
          FN_NOR:  slot.ctrl = CTRL_NOR;
          default: begin
            slot  = '0;
            legal = 1'b0;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        // Logic immediates are zero-extended, not sign-extended.
        slot.a    = rs_val;
        slot.b    = {16'h0000, imm};
        slot.dest = instr[20:16];
        legal     = 1'b1;
        case (op)
          OP_ANDI: slot.ctrl = CTRL_AND;
          OP_ORI:  slot.ctrl = CTRL_OR;
          default: slot.ctrl = CTRL_XOR;
        endcase
      end
      OP_LUI: begin
        // LUI is issued as a pass-through of the pre-shifted immediate.
        slot.ctrl = CTRL_PASS_A;
        slot.a    = {imm, 16'h0000};
        slot.b    = '0;
        slot.dest = instr[20:16];
        legal     = 1'b1;
      end
      default: begin
        slot  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/logic_op_issue.sv
// Issue stage feeding the logic unit. Decodes one MIPS logic instruction per
// cycle into a registered issue slot offered downstream with valid/ready.
// Illegal encodings are consumed, pulsed on 'illegal' and counted.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop the held slot, refuse input this cycle
//   in_valid/in_ready        upstream handshake
//   in_instr, in_rs_val, in_rt_val  instruction and register operands
//   out_valid/out_ready      downstream handshake
//   out_ctrl, out_a, out_b, out_dest  issue slot contents
//   illegal                  one-cycle pulse per consumed illegal instruction
//   illegal_cnt              saturating count of illegal instructions
module logic_op_issue
  import logic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_ctrl,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [4:0]       out_dest,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  issue_slot_t      dec_slot;
  logic             dec_legal;
  issue_slot_t      slot_reg;
  logic             valid_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;

  logic_op_decode u_decode (
    .instr  (in_instr),
    .rs_val (in_rs_val),
    .rt_val (in_rt_val),
    .slot   (dec_slot),
    .legal  (dec_legal)
  );

  // Ready looks through the slot when it is retiring this cycle, giving
  // full throughput without a skid buffer.
  assign in_ready = !flush && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg    <= '0;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      illegal_reg <= accept && !dec_legal;
      if (accept && !dec_legal && cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (flush) begin
        valid_reg <= 1'b0;
      end else if (accept) begin
        // An accept implies the slot is empty or retiring, so an illegal
        // accept simply leaves it empty. Fields hold on illegal.
        valid_reg <= dec_legal;
        if (dec_legal) begin
          slot_reg <= dec_slot;
        end
      end else if (valid_reg && out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_reg;
  assign out_ctrl    = slot_reg.ctrl;
  assign out_a       = slot_reg.a;
  assign out_b       = slot_reg.b;
  assign out_dest    = slot_reg.dest;
  assign illegal     = illegal_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_logic_op_issue.sv
module tb_logic_op_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_dest;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int failures = 0;

  // Reference state: what the issue slot should hold.
  bit          m_valid;
  logic [3:0]  m_ctrl;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_dest;
  bit          m_ill;
  int          m_cnt;

  always #5 clk = ~clk;

  logic_op_issue #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b), .out_dest(out_dest),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                            output bit lg, output logic [3:0] c, output logic [31:0] a,
                            output logic [31:0] b, output logic [4:0] d);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    lg = 1; c = 0; a = 0; b = 0; d = 0;
    if (op == 0 && fn >= 36 && fn <= 39) begin
      c = (fn == 36) ? 4'b1000 : (fn == 37) ? 4'b1110 : (fn == 38) ? 4'b0110 : 4'b0001;
      a = rs; b = rt; d = ins[15:11];
    end else if (op >= 12 && op <= 14) begin
      c = (op == 12) ? 4'b1000 : (op == 13) ? 4'b1110 : 4'b0110;
      a = rs; b = 32'(ins[15:0]); d = ins[20:16];
    end else if (op == 15) begin
      c = 4'b1010; a = 32'(ins[15:0]) << 16; b = 0; d = ins[20:16];
    end else begin
      lg = 0;
    end
  endtask

  // One clock: inputs were driven at the previous negedge.
  task automatic cycle();
    bit rdy, acc, lg;
    logic [3:0] c;
    logic [31:0] a, b;
    logic [4:0] d;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    ref_decode(in_instr, in_rs_val, in_rt_val, lg, c, a, b, d);
    if (acc && !rst)
      $display("txn instr=%08h legal=%0d ctrl=%04b a=%08h b=%08h dest=%0d", in_instr, lg, c, a, b, d);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_dest = 0; m_ill = 0; m_cnt = 0;
    end else begin
      m_ill = acc && !lg;
      if (m_ill) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = lg;
        if (lg) begin m_ctrl = c; m_a = a; m_b = b; m_dest = d; end
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    check("out_ctrl", out_ctrl, m_ctrl);
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("out_dest", out_dest, m_dest);
    check("illegal", illegal, m_ill);
    check("illegal_cnt", illegal_cnt, m_cnt);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input bit ordy);
    in_valid = v; in_instr = ins; in_rs_val = rs; in_rt_val = rt; out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0] fn;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: begin fn = 6'(36 + $urandom_range(0, 3)); w[31:26] = 6'd0; w[5:0] = fn; end
      1: w[31:26] = 6'(12 + $urandom_range(0, 2));
      2: w[31:26] = 6'd15;
      3: begin w[31:26] = 6'd0; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Reset
    rst = 1; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ctrl", out_ctrl, 0);
    check("rst_a", out_a, 0);
    check("rst_b", out_b, 0);
    check("rst_dest", out_dest, 0);
    check("rst_ill", illegal, 0);
    check("rst_cnt", illegal_cnt, 0);
    m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_dest = 0; m_ill = 0; m_cnt = 0;
    rst = 0;

    // 1: AND $3,$1,$2
    drive(1, 32'h00221824, 32'hF0F0F0F0, 32'hFF00FF00, 1);
    cycle();
    check("t1_ctrl", out_ctrl, 4'b1000);
    check("t1_a", out_a, 32'hF0F0F0F0);
    check("t1_b", out_b, 32'hFF00FF00);
    check("t1_dest", out_dest, 3);

    // 2: ORI $5,$4,0xBEEF then LUI $6,0x1234 back-to-back
    drive(1, 32'h3485BEEF, 32'h11111111, 32'h22222222, 1);
    cycle();
    check("t2_ori_ctrl", out_ctrl, 4'b1110);
    check("t2_ori_b", out_b, 32'h0000BEEF);
    check("t2_ori_dest", out_dest, 5);
    drive(1, 32'h3C061234, 32'h33333333, 32'h44444444, 1);
    cycle();
    check("t2_lui_ctrl", out_ctrl, 4'b1010);
    check("t2_lui_a", out_a, 32'h12340000);
    check("t2_lui_b", out_b, 0);
    check("t2_lui_dest", out_dest, 6);
    check("t2_valid", out_valid, 1);

    // 3: backpressure with a pending instruction
    drive(1, 32'h00A63027, 32'h0000FFFF, 32'h00FF00FF, 0);   // NOR $6,$5,$6
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_frozen_a", out_a, 32'h12340000);
    end
    out_ready = 1;
    cycle();
    check("t3_drain_ctrl", out_ctrl, 4'b0001);
    check("t3_drain_b", out_b, 32'h00FF00FF);

    // 4: illegal LW, then saturation
    drive(1, 32'h8C000000, 0, 0, 1);
    cycle();
    check("t4_pulse", illegal, 1);
    check("t4_cnt", illegal_cnt, 1);
    check("t4_noissue", out_valid, 0);
    for (int i = 0; i < 300; i++) cycle();
    check("t4_sat", illegal_cnt, 255);
    in_valid = 0;
    cycle();
    check("t4_pulse_end", illegal, 0);

    // 5: flush with a held slot
    drive(1, 32'h00221825, 32'h1, 32'h2, 0);   // OR $3,$1,$2
    cycle();
    flush = 1;
    drive(1, 32'h00221826, 32'h5, 32'h6, 0);
    cycle();
    check("t5_flushed", out_valid, 0);
    flush = 0;
    in_valid = 0;
    cycle();
    check("t5_not_consumed", out_valid, 0);

    // 6: reset with slot held and cnt=7
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 7; i++) begin drive(1, 32'hFC000000, 0, 0, 1); cycle(); end
    drive(1, 32'h3C07ABCD, 0, 0, 0);
    cycle();
    check("t6_cnt7", illegal_cnt, 7);
    rst = 1;
    cycle();
    rst = 0; in_valid = 0;
    check("t6_valid", out_valid, 0);
    check("t6_cnt", illegal_cnt, 0);
    check("t6_a", out_a, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom_range(0, 9) < 7);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
